mem_arbiter: RTL and testbench

//  Shares the single-port 256x16 program/data RAM between two requesters:

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port request/ack arbiter in front of a single-port sync-read RAM
module mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WDATA,
  output logic          A_ACK,
  output logic [DW-1:0] A_RDATA,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WDATA,
  output logic          B_ACK,
  output logic [DW-1:0] B_RDATA,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  output logic          BUSY
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic          m_en_q, m_we_q, a_ack_q, b_ack_q, busy_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          owner_b_q;   // port that owns the access in flight
  logic          rd_q;        // access in flight is a read
  logic          prefer_b_q;  // round-robin pointer: next tie goes to B
  logic [CW-1:0] wait_q;      // B starvation counter (fixed-priority mode)
  logic          grant_b_d;

  always_comb begin
    grant_b_d = B_REQ;
    if (A_REQ && B_REQ) begin
      if (RR_MODE != 0) grant_b_d = prefer_b_q;
      else              grant_b_d = (wait_q >= LIMIT);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= IDLE;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      owner_b_q  <= 1'b0;
      rd_q       <= 1'b0;
      prefer_b_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (A_REQ || B_REQ) begin
            m_en_q     <= 1'b1;
            m_we_q     <= grant_b_d ? B_WE    : A_WE;
            m_addr_q   <= grant_b_d ? B_ADDR  : A_ADDR;
            m_wdata_q  <= grant_b_d ? B_WDATA : A_WDATA;
            rd_q       <= grant_b_d ? !B_WE   : !A_WE;
            owner_b_q  <= grant_b_d;
            prefer_b_q <= !grant_b_d;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
            if (grant_b_d)
              wait_q <= '0;
            else if (B_REQ && (wait_q < LIMIT))
              wait_q <= wait_q + CW'(1);
          end else begin
            m_en_q <= 1'b0;
          end
        end
        ACCESS: begin
          m_en_q  <= 1'b0;
          m_we_q  <= 1'b0;
          a_ack_q <= !owner_b_q;
          b_ack_q <= owner_b_q;
          state_q <= RESP;
        end
        RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_EN    = m_en_q;
  assign M_WE    = m_we_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;
  assign A_ACK   = a_ack_q;
  assign B_ACK   = b_ack_q;
  assign BUSY    = busy_q;
  // RAM output is live exactly during the ACK cycle, so read data is steered from it directly
  assign A_RDATA = (a_ack_q && rd_q) ? M_RDATA : '0;
  assign B_RDATA = (b_ack_q && rd_q) ? M_RDATA : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (round-robin and fixed-priority instances)
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;

  logic        a_ack [2];
  logic        b_ack [2];
  logic        m_en  [2];
  logic        m_we  [2];
  logic        busy  [2];
  logic [7:0]  m_addr [2];
  logic [15:0] a_rd [2];
  logic [15:0] b_rd [2];
  logic [15:0] m_wd [2];
  logic [15:0] m_rd [2];
  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.AW(8), .DW(16), .RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
    .CLK(CLK), .CLR(CLR),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(a_ack[0]), .A_RDATA(a_rd[0]),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(b_ack[0]), .B_RDATA(b_rd[0]),
    .M_EN(m_en[0]), .M_WE(m_we[0]), .M_ADDR(m_addr[0]), .M_WDATA(m_wd[0]),
    .M_RDATA(m_rd[0]), .BUSY(busy[0])
  );

  mem_arbiter #(.AW(8), .DW(16), .RR_MODE(0), .STARVE_LIMIT(4)) u_fp (
    .CLK(CLK), .CLR(CLR),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(a_ack[1]), .A_RDATA(a_rd[1]),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(b_ack[1]), .B_RDATA(b_rd[1]),
    .M_EN(m_en[1]), .M_WE(m_we[1]), .M_ADDR(m_addr[1]), .M_WDATA(m_wd[1]),
    .M_RDATA(m_rd[1]), .BUSY(busy[1])
  );

  always @(posedge CLK) begin
    if (m_en[0]) begin
      if (m_we[0]) ram0[m_addr[0]] <= m_wd[0];
      m_rd[0] <= ram0[m_addr[0]];
    end
  end

  always @(posedge CLK) begin
    if (m_en[1]) begin
      if (m_we[1]) ram1[m_addr[1]] <= m_wd[1];
      m_rd[1] <= ram1[m_addr[1]];
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic single(input logic pb, input logic we, input logic [7:0] ad,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    end
    tick;
    chk({tag, ".m_en"},   {31'd0, m_en[0]}, 32'd1);
    chk({tag, ".m_addr"}, {24'd0, m_addr[0]}, {24'd0, ad});
    chk({tag, ".m_we"},   {31'd0, m_we[0]}, {31'd0, we});
    chk({tag, ".busy"},   {31'd0, busy[0]}, 32'd1);
    chk({tag, ".ack_early"}, {30'd0, a_ack[0], b_ack[0]}, 32'd0);
    if (we) chk({tag, ".m_wdata"}, {16'd0, m_wd[0]}, {16'd0, wd});
    tick;
    chk({tag, ".ack"}, {30'd0, a_ack[0], b_ack[0]}, pb ? 32'd1 : 32'd2);
    chk({tag, ".rdata"}, {16'd0, pb ? b_rd[0] : a_rd[0]}, {16'd0, we ? 16'd0 : exp_rd});
    chk({tag, ".other_rdata"}, {16'd0, pb ? a_rd[0] : b_rd[0]}, 32'd0);
    chk({tag, ".m_en_off"}, {31'd0, m_en[0]}, 32'd0);
    a_req = 1'b0;
    b_req = 1'b0;
    tick;
    chk({tag, ".ack_done"}, {30'd0, a_ack[0], b_ack[0]}, 32'd0);
    chk({tag, ".busy_done"}, {31'd0, busy[0]}, 32'd0);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'hA000 + 16'(i);
      ram1[i] = 16'hA000 + 16'(i);
    end
    ram0[7] = 16'h0005;
    ram1[7] = 16'h0005;

    tick;
    tick;
    for (int k = 0; k < 2; k++) begin
      chk("rst.ctrl", {27'd0, m_en[k], m_we[k], a_ack[k], b_ack[k], busy[k]}, 32'd0);
      chk("rst.addr", {24'd0, m_addr[k]}, 32'd0);
      chk("rst.wdata", {16'd0, m_wd[k]}, 32'd0);
      chk("rst.rdata", {a_rd[k], b_rd[k]}, 32'd0);
    end
    CLR = 1'b0;
    tick;

    single(1'b0, 1'b0, 8'h07, 16'h0000, 16'h0005, "t1");
    single(1'b1, 1'b1, 8'h08, 16'h000C, 16'h0000, "t2w");
    single(1'b0, 1'b0, 8'h08, 16'h0000, 16'h000C, "t2r");

    // Both ports held: RR instance alternates A,B; fixed instance gives B every fifth slot
    CLR = 1'b1;
    tick;
    CLR = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    for (int n = 0; n < 10; n++) begin
      tick;
      chk("t3.rr_addr", {24'd0, m_addr[0]}, (n % 2 == 1) ? 32'h20 : 32'h10);
      chk("t4.fp_addr", {24'd0, m_addr[1]}, (n % 5 == 4) ? 32'h20 : 32'h10);
      tick;
      chk("t3.rr_ack", {30'd0, a_ack[0], b_ack[0]}, (n % 2 == 1) ? 32'd1 : 32'd2);
      chk("t3.rr_rdata", {a_rd[0], b_rd[0]},
          (n % 2 == 1) ? 32'h0000A020 : 32'hA0100000);
      chk("t4.fp_ack", {30'd0, a_ack[1], b_ack[1]}, (n % 5 == 4) ? 32'd1 : 32'd2);
      tick;
      chk("t3.ack_gap", {28'd0, a_ack[0], b_ack[0], a_ack[1], b_ack[1]}, 32'd0);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick;

    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h07;
    tick;
    chk("t5.access", {31'd0, m_en[0]}, 32'd1);
    #2;
    CLR = 1'b1;
    #1;
    chk("t5.clr_ctrl", {29'd0, m_en[0], busy[0], a_ack[0]}, 32'd0);
    chk("t5.clr_addr", {24'd0, m_addr[0]}, 32'd0);
    a_req = 1'b0;
    tick;
    chk("t5.no_ack", {30'd0, a_ack[0], m_en[0]}, 32'd0);
    CLR = 1'b0;
    tick;
    chk("t5.still_idle", {29'd0, a_ack[0], m_en[0], busy[0]}, 32'd0);
    single(1'b0, 1'b0, 8'h07, 16'h0000, 16'h0005, "t5re");

    a_req = 1'b1;
    a_we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_addr = 8'(i);
      tick;
      chk("t6.addr", {24'd0, m_addr[0]}, 32'(i));
      chk("t6.m_en", {31'd0, m_en[0]}, 32'd1);
      tick;
      chk("t6.ack", {31'd0, a_ack[0]}, 32'd1);
      chk("t6.rdata", {16'd0, a_rd[0]}, 32'hA000 + 32'(i));
      if (i == 3) a_req = 1'b0;
      tick;
      chk("t6.ack_low", {31'd0, a_ack[0]}, 32'd0);
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      chk("t6.no_extra", {29'd0, a_ack[0], m_en[0], busy[0]}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
